// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file and its dump engine.
package regfile_pkg;

    localparam int unsigned DefXlen  = 32;
    localparam int unsigned DefNregs = 32;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } dump_state_e;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int unsigned DefAw = addr_width(DefNregs);

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump engine: walks every register index once and streams it over a valid/ready channel.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN  = DefXlen,
    parameter  int unsigned NREGS = DefNregs,
    localparam int unsigned AW    = addr_width(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            ready_i,
    output logic [AW-1:0]   rd_idx_o,
    input  logic [XLEN-1:0] rd_data_i,
    output logic            valid_o,
    output logic [AW-1:0]   idx_o,
    output logic [XLEN-1:0] data_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

    dump_state_e   state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSend;
                    idx_d   = '0;
                end
            end
            StSend: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                if (ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
                idx_d   = '0;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // Data is a live read of the current index, so it follows same-cycle writes.
    assign rd_idx_o = idx_q;
    assign idx_o    = idx_q;
    assign data_o   = rd_data_i;

    hold_until_accepted : assert property (@(posedge clk) disable iff (reset)
        (valid_o && !ready_i) |=> (valid_o && $stable(idx_o)));

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write bypass, hardwired x0 and a dump port.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN     = DefXlen,
    parameter  int unsigned NREGS    = DefNregs,
    parameter  int unsigned NREAD    = 2,
    parameter  bit          BYPASS   = 1'b1,
    parameter  bit          ZERO_REG = 1'b1,
    localparam int unsigned AW       = addr_width(NREGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREAD-1:0][AW-1:0]   rd_addr,
    output logic [NREAD-1:0][XLEN-1:0] rd_data,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic                       dump_start,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [AW-1:0]              dump_idx,
    output logic [XLEN-1:0]            dump_data,
    output logic                       dump_busy,
    output logic                       dump_done
);

    logic [XLEN-1:0]          regs_q [NREGS];
    logic [XLEN-1:0]          regs_d [NREGS];
    logic                     wr_legal;
    logic [AW-1:0]            dump_rd_idx;
    logic [XLEN-1:0]          dump_rd_data;
    logic [NREAD:0][AW-1:0]   raddr;
    logic [NREAD:0][XLEN-1:0] rdata;

    assign wr_legal = wr_en && !(ZERO_REG && (wr_addr == '0));

    always_comb begin
        regs_d = regs_q;
        if (wr_legal) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Top slot is the dump engine's private port; it shares the exact read semantics.
    assign raddr = {dump_rd_idx, rd_addr};

    always_comb begin
        for (int p = 0; p <= NREAD; p++) begin
            if (ZERO_REG && (raddr[p] == '0)) begin
                rdata[p] = '0;
            end else if (BYPASS && wr_legal && (wr_addr == raddr[p])) begin
                rdata[p] = wr_data;
            end else begin
                rdata[p] = regs_q[raddr[p]];
            end
        end
    end

    assign rd_data      = rdata[NREAD-1:0];
    assign dump_rd_data = rdata[NREAD];

    regfile_dump_fsm #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_dump_fsm (
        .clk       (clk),
        .reset     (reset),
        .start_i   (dump_start),
        .ready_i   (dump_ready),
        .rd_idx_o  (dump_rd_idx),
        .rd_data_i (dump_rd_data),
        .valid_o   (dump_valid),
        .idx_o     (dump_idx),
        .data_o    (dump_data),
        .busy_o    (dump_busy),
        .done_o    (dump_done)
    );

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor of the core's integer register bank, with N combinational read ports, one synchronous write port, an optional write-to-read bypass and a hardwired-zero option. It replaces simulation-only register printing with a synthesizable dump engine. The engine streams every register over a valid/ready channel so trace logic or a UART bridge can capture architectural state. It sits in the decode stage of the RV32 pipeline; the dump port goes to the debug/trace unit.

Parameters:
XLEN, 32, register width in bits
NREGS, 32, number of registers (power of two, >=2)
NREAD, 2, number of read ports
BYPASS, 1, 1 = read port returns wr_data when reading the register being written this cycle
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
rd_addr  in  NREAD x log2(NREGS)  read addresses
rd_data  out  NREAD x XLEN  read data
wr_en  in  1  write enable
wr_addr  in  log2(NREGS)  write address
wr_data  in  XLEN  write data
dump_start  in  1  single-cycle pulse requesting a full dump
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts beat
dump_idx  out  log2(NREGS)  register index of current beat
dump_data  out  XLEN  register value of current beat
dump_busy  out  1  dump in progress
dump_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset, asynchronous: all registers 0; FSM to IDLE; dump_valid=0, dump_busy=0, dump_done=0, dump_idx=0. A reset mid-dump aborts it; no dump_done is issued.
- Write: at posedge clk, if wr_en and not (ZERO_REG and wr_addr==0), reg[wr_addr] <= wr_data.
- Read: combinational, zero latency. For each port p:
  - if ZERO_REG and rd_addr[p]==0, output 0;
  - else if BYPASS and wr_en and wr_addr==rd_addr[p] (and a write is legal), output wr_data;
  - else output reg[rd_addr[p]].
  - Read ports are independent; the same address on several ports is allowed.
- Dump FSM states IDLE, SEND, DONE:
  - IDLE: dump_start=1 -> SEND, idx=0, busy=1.
  - SEND: dump_valid=1, dump_data = current register value (live, BYPASS rules apply via an internal read of idx). A transfer occurs on valid&&ready. On transfer with idx==NREGS-1 -> DONE; otherwise idx+1. dump_valid stays high and idx/data stay stable until ready, except data tracks same-cycle writes to idx.
  - DONE: dump_done=1 for one cycle, busy=0, valid=0 -> IDLE.
- dump_start while busy or in DONE is ignored; no queuing.
- Writes during a dump are allowed:
  - a write to a not-yet-sent index is seen in its beat;
  - a write to an already-sent index is not re-sent.
- Normal reads/writes are never stalled by the dump.
- dump_idx wraps only via DONE→IDLE (reset to 0); there is no counter overflow path.

Decomposition:
- Package regfile_pkg: dump_state_e enum (IDLE, SEND, DONE); localparam helper for address width (clog2 of NREGS); default XLEN/NREGS constants shared with decode.
- One sub-module regfile_dump_fsm: owns state, index counter and handshake. It gets read access through a dedicated internal read port. Storage and bypass muxing stay in the top.

Test Plan:
- Reset then read all addresses on both ports -> every rd_data = 0; assert reset mid-cycle asynchronously -> outputs 0 before the next edge.
- Write x5=0xDEADBEEF, next cycle rd_addr[0]=5 -> 0xDEADBEEF; write x0=0x1234 with ZERO_REG=1 -> x0 reads 0.
- Same-cycle write x7=42 and read x7 with BYPASS=1 -> rd_data 42 that cycle; with BYPASS=0 -> old value 0, 42 next cycle.
- dump_start with ready always 1 after loading x[i]=i*3 -> 32 beats idx 0..31, data 0,3,..,93 on consecutive cycles; dump_done pulses once, cycle after idx 31 accepted.
- Dump with ready toggling 1/0 -> beats held stable while ready=0; no index skipped or duplicated; a second dump_start mid-dump is ignored.
- During dump at idx=10: write x20=77 and x3=55 -> beat 20 shows 77, x3 is not re-sent. Assert reset at idx=15 -> valid=0, busy=0, no dump_done; a new dump_start restarts from idx 0.
